// File: rtl/mem_arbiter.sv
// Two-master arbiter (core C, debug D) sharing one data-memory/MMIO port.
// Optional round-robin tie-break enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          memwrite,
    output logic          memread,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] writedata,
    input  logic [DW-1:0] readdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   lat_we;
    logic   win;
    logic   sel_we;

    // Winner: 0 = core, 1 = debug; only meaningful when a request is present.
    always_comb begin
        win = ~c_req;
`ifdef MEM_ARB_RR_EN
        if (c_req && d_req) begin
            win = ~owner;
        end
`endif
        sel_we = win ? d_we : c_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            c_ack     <= 1'b0;
            d_ack     <= 1'b0;
            c_rdata   <= '0;
            d_rdata   <= '0;
            memwrite  <= 1'b0;
            memread   <= 1'b0;
            addr      <= '0;
            writedata <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req || d_req) begin
                        owner     <= win;
                        lat_we    <= sel_we;
                        addr      <= win ? d_addr : c_addr;
                        writedata <= win ? d_wdata : c_wdata;
                        memwrite  <= sel_we;
                        memread   <= ~sel_we;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    memwrite <= 1'b0;
                    memread  <= 1'b0;
                    // Only the winner's read register moves, and only on reads.
                    if (!lat_we) begin
                        if (owner) begin
                            d_rdata <= readdata;
                        end else begin
                            c_rdata <= readdata;
                        end
                    end
                    c_ack <= ~owner;
                    d_ack <= owner;
                    state <= DONE;
                end
                DONE: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
